// File: rtl/tqvp_hx2003_pulse_pkg.sv
//==============================================================================
// Module      : tqvp_hx2003_pulse_pkg
// Description : Shared constants for the pulse sequencer: FSM state encoding,
//               symbol level bit position and default sizing.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package tqvp_hx2003_pulse_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_DUR_W = 15;

    // Level bit sits just above the duration field in a symbol word.
    localparam int SYM_LEVEL_BIT = DEFAULT_DUR_W;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/tqvp_hx2003_pulse_if.sv
//==============================================================================
// Module      : tqvp_hx2003_pulse_if
// Description : Register-side bus of the pulse sequencer.
//               master : TinyQV register block (pushes symbols, strobes)
//               slave  : sequencer (ready, status, interrupt)
//               Signals: sym_data/sym_valid/sym_ready, start, abort, irq_clr,
//                        busy, fifo_level, done_irq.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface tqvp_hx2003_pulse_if #(
    parameter int DUR_W = 15,
    parameter int DEPTH = 8
);
    logic [DUR_W:0]         sym_data;
    logic                   sym_valid;
    logic                   sym_ready;
    logic                   start;
    logic                   abort;
    logic                   irq_clr;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   done_irq;

    modport master (
        output sym_data, sym_valid, start, abort, irq_clr,
        input  sym_ready, busy, fifo_level, done_irq
    );

    modport slave (
        input  sym_data, sym_valid, start, abort, irq_clr,
        output sym_ready, busy, fifo_level, done_irq
    );
endinterface

`default_nettype wire

// File: rtl/tqvp_hx2003_sym_fifo.sv
//==============================================================================
// Module      : tqvp_hx2003_sym_fifo
// Description : Synchronous symbol FIFO, DEPTH x W, with flush.
//               Ports: clk, rst_n, push, pop, flush, wdata, rdata (head),
//                      full, empty, level (0..DEPTH).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tqvp_hx2003_sym_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire logic                   flush,
    input  wire logic [W-1:0]           wdata,
    output logic      [W-1:0]           rdata,
    output logic                        full,
    output logic                        empty,
    output logic      [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_level == (AW+1)'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rdata     = r_mem[r_rptr];
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    // Storage carries no reset: the level counter alone defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - (AW+1)'(1);
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/tqvp_hx2003_pulse_sequencer.sv
//==============================================================================
// Module      : tqvp_hx2003_pulse_sequencer
// Description : Buffers mark/space symbols and gates the carrier onto tx_out
//               for each symbol's duration in timebase ticks.
//               Ports: clk, rst_n, tick, carrier_in, tx_out, mark,
//                      bus (tqvp_hx2003_pulse_if.slave),
//                      prescale[7:0] when PULSE_SEQ_PRESCALE_EN is defined.
//               Macro PULSE_SEQ_PRESCALE_EN: tick prescaler, one effective
//               tick every prescale+1 input ticks, phase-aligned per symbol.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tqvp_hx2003_pulse_sequencer
    import tqvp_hx2003_pulse_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DUR_W = DEFAULT_DUR_W
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       tick,
    input  wire logic       carrier_in,
`ifdef PULSE_SEQ_PRESCALE_EN
    input  wire logic [7:0] prescale,
`endif
    output logic            tx_out,
    output logic            mark,
    tqvp_hx2003_pulse_if.slave bus
);
    state_t             r_state;
    logic [DUR_W-1:0]   r_count;
    logic               r_mark;
    logic               r_irq;

    logic [DUR_W:0]     w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_eff_tick;
    logic               w_sym_end;
    logic [DUR_W-1:0]   w_head_cnt;

    assign bus.sym_ready = !w_full && !bus.abort;
    assign w_push        = bus.sym_valid && bus.sym_ready;
    assign w_sym_end     = (r_state == ST_RUN) && w_eff_tick && (r_count == DUR_W'(1));
    assign w_pop         = (r_state == ST_LOAD) || (w_sym_end && !w_empty);
    // Zero duration is stretched to one tick.
    assign w_head_cnt    = (w_head[DUR_W-1:0] == '0) ? DUR_W'(1) : w_head[DUR_W-1:0];

    assign mark          = r_mark;
    assign tx_out        = r_mark & carrier_in;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done_irq  = r_irq;

`ifdef PULSE_SEQ_PRESCALE_EN
    logic [7:0] r_pre;

    assign w_eff_tick = tick && (r_pre == 8'd0);

    // Reloading on LOAD and on every effective tick (which includes every
    // symbol transition) keeps each symbol phase-aligned to its own start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= 8'd0;
        end else if (r_state == ST_LOAD) begin
            r_pre <= prescale;
        end else if (tick) begin
            r_pre <= (r_pre == 8'd0) ? prescale : r_pre - 8'd1;
        end
    end
`else
    assign w_eff_tick = tick;
`endif

    tqvp_hx2003_sym_fifo #(
        .DEPTH (DEPTH),
        .W     (DUR_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (bus.abort),
        .wdata (bus.sym_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (bus.fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_mark  <= 1'b0;
        end else if (bus.abort) begin
            r_state <= ST_IDLE;
            r_mark  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !w_empty) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_count <= w_head_cnt;
                    r_mark  <= w_head[DUR_W];
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_sym_end) begin
                        if (!w_empty) begin
                            r_count <= w_head_cnt;
                            r_mark  <= w_head[DUR_W];
                        end else begin
                            r_state <= ST_IDLE;
                            r_mark  <= 1'b0;
                        end
                    end else if (w_eff_tick) begin
                        r_count <= r_count - DUR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_mark  <= 1'b0;
                end
            endcase
        end
    end

    // Completion beats a simultaneous clear; abort leaves the flag alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else if (w_sym_end && w_empty && !bus.abort) begin
            r_irq <= 1'b1;
        end else if (bus.irq_clr) begin
            r_irq <= 1'b0;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_tqvp_hx2003_pulse_sequencer.sv
//==============================================================================
// Module      : tb_tqvp_hx2003_pulse_sequencer
// Description : Directed self-checking bench for the pulse sequencer.
//               Covers PULSE_SEQ_PRESCALE_EN when that macro is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tqvp_hx2003_pulse_sequencer;
    localparam int DEPTH = 8;
    localparam int DUR_W = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic tick;
    logic carrier_in;
    logic tx_out;
    logic mark;
`ifdef PULSE_SEQ_PRESCALE_EN
    logic [7:0] prescale;
`endif

    int n_cmp = 0;
    int n_err = 0;

    tqvp_hx2003_pulse_if #(.DUR_W(DUR_W), .DEPTH(DEPTH)) bus ();

    tqvp_hx2003_pulse_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .carrier_in (carrier_in),
`ifdef PULSE_SEQ_PRESCALE_EN
        .prescale   (prescale),
`endif
        .tx_out     (tx_out),
        .mark       (mark),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic lvl, input logic [DUR_W-1:0] dur);
        bus.sym_data  = {lvl, dur};
        bus.sym_valid = 1'b1;
        step();
        bus.sym_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_mark [6];
        int   hi_cnt;

        rst_n = 1'b0; tick = 1'b0; carrier_in = 1'b1;
        bus.sym_data = '0; bus.sym_valid = 1'b0; bus.start = 1'b0;
        bus.abort = 1'b0; bus.irq_clr = 1'b0;
`ifdef PULSE_SEQ_PRESCALE_EN
        prescale = 8'd0;
`endif
        #12;
        check("rst_mark",  {31'd0, mark},        32'd0);
        check("rst_tx",    {31'd0, tx_out},      32'd0);
        check("rst_busy",  {31'd0, bus.busy},    32'd0);
        check("rst_irq",   {31'd0, bus.done_irq},32'd0);
        check("rst_level", 32'(bus.fifo_level),  32'd0);
        check("rst_ready", {31'd0, bus.sym_ready},32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic playout: {1,3},{0,2} with tick every cycle.
        push(1'b1, 15'd3);
        push(1'b0, 15'd2);
        check("a_level", 32'(bus.fifo_level), 32'd2);
        tick = 1'b1;
        pulse_start();
        check("a_load_busy", {31'd0, bus.busy}, 32'd1);
        check("a_load_mark", {31'd0, mark}, 32'd0);
        step(); check("a_m1", {31'd0, mark}, 32'd1);
        check("a_tx_on", {31'd0, tx_out}, 32'd1);
        carrier_in = 1'b0; #1;
        check("a_tx_carrier_low", {31'd0, tx_out}, 32'd0);
        carrier_in = 1'b1;
        step(); check("a_m2", {31'd0, mark}, 32'd1);
        step(); check("a_m3", {31'd0, mark}, 32'd1);
        step(); check("a_s1", {31'd0, mark}, 32'd0);
        check("a_tx_space", {31'd0, tx_out}, 32'd0);
        step(); check("a_s2", {31'd0, mark}, 32'd0);
        check("a_s2_busy", {31'd0, bus.busy}, 32'd1);
        check("a_s2_irq", {31'd0, bus.done_irq}, 32'd0);
        step(); check("a_end_busy", {31'd0, bus.busy}, 32'd0);
        check("a_end_irq", {31'd0, bus.done_irq}, 32'd1);
        tick = 1'b0;

        bus.irq_clr = 1'b1; step(); bus.irq_clr = 1'b0;
        check("clr_alone", {31'd0, bus.done_irq}, 32'd0);

        pulse_start();
        check("start_empty_busy", {31'd0, bus.busy}, 32'd0);
        step();
        check("start_empty_irq", {31'd0, bus.done_irq}, 32'd0);

        // Fill to DEPTH, then try a ninth push.
        for (int i = 0; i < DEPTH; i++) push(1'b1, 15'd1);
        check("full_level", 32'(bus.fifo_level), 32'd8);
        check("full_ready", {31'd0, bus.sym_ready}, 32'd0);
        push(1'b0, 15'd1);
        check("full_9th", 32'(bus.fifo_level), 32'd8);
        pulse_start();
        step();
        check("run_level", 32'(bus.fifo_level), 32'd7);
        check("run_mark", {31'd0, mark}, 32'd1);
        // Symbol-ending tick pops while a push lands: level unchanged.
        tick = 1'b1;
        push(1'b1, 15'd1);
        tick = 1'b0;
        check("pushpop_level", 32'(bus.fifo_level), 32'd7);
        check("pushpop_busy", {31'd0, bus.busy}, 32'd1);

        // Abort with a concurrent push, queue non-empty.
        bus.abort = 1'b1; bus.sym_valid = 1'b1; bus.sym_data = {1'b1, 15'd4};
        #1;
        check("abort_ready", {31'd0, bus.sym_ready}, 32'd0);
        step();
        bus.abort = 1'b0; bus.sym_valid = 1'b0;
        check("abort_mark", {31'd0, mark}, 32'd0);
        check("abort_level", 32'(bus.fifo_level), 32'd0);
        check("abort_irq", {31'd0, bus.done_irq}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        pulse_start();
        check("abort_restart", {31'd0, bus.busy}, 32'd0);

        // D=0 space between two D=2 marks; irq_clr collides with completion.
        push(1'b1, 15'd2);
        push(1'b0, 15'd0);
        push(1'b1, 15'd2);
        exp_mark = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tick = 1'b1;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.irq_clr = 1'b1;
            step();
            check($sformatf("z_mark%0d", i), {31'd0, mark}, {31'd0, exp_mark[i]});
            if (i < 5) check($sformatf("z_busy%0d", i), {31'd0, bus.busy}, 32'd1);
        end
        bus.irq_clr = 1'b0;
        tick = 1'b0;
        check("z_set_wins", {31'd0, bus.done_irq}, 32'd1);
        check("z_idle", {31'd0, bus.busy}, 32'd0);
        bus.irq_clr = 1'b1; step(); bus.irq_clr = 1'b0;
        check("z_clr", {31'd0, bus.done_irq}, 32'd0);

`ifdef PULSE_SEQ_PRESCALE_EN
        prescale = 8'd3;
        push(1'b1, 15'd2);
        tick = 1'b1;
        pulse_start();
        hi_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mark) hi_cnt++;
        end
        tick = 1'b0;
        check("pre_mark_ticks", 32'(hi_cnt), 32'd8);
        check("pre_irq", {31'd0, bus.done_irq}, 32'd1);
        bus.irq_clr = 1'b1; step(); bus.irq_clr = 1'b0;
        prescale = 8'd0;
`else
        hi_cnt = 0;
`endif

        // Asynchronous reset mid-sequence.
        push(1'b1, 15'd5);
        push(1'b1, 15'd5);
        tick = 1'b1;
        pulse_start();
        step();
        step();
        check("pre_rst_mark", {31'd0, mark}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mark", {31'd0, mark}, 32'd0);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_level", 32'(bus.fifo_level), 32'd0);
        check("arst_ready", {31'd0, bus.sym_ready}, 32'd1);
        tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
